// File: rtl/rc4_xor_stage_if.sv
// Handshake and status bundle between the RC4 keystream XOR stage and its neighbours.
// The slave modport is the stage itself; the master side drives keystream and plaintext.
interface rc4_xor_stage_if;
  logic        ks_valid;
  logic [7:0]  ks_byte;
  logic        pt_valid;
  logic [7:0]  pt_data;
  logic        pt_ready;
  logic        ct_valid;
  logic [7:0]  ct_data;
  logic        ct_ready;
  logic        running;
  logic        overflow;
  logic [15:0] byte_count;

  modport master (
    output ks_valid, ks_byte, pt_valid, pt_data, ct_ready,
    input  pt_ready, ct_valid, ct_data, running, overflow, byte_count
  );

  modport slave (
    input  ks_valid, ks_byte, pt_valid, pt_data, ct_ready,
    output pt_ready, ct_valid, ct_data, running, overflow, byte_count
  );
endinterface

// File: rtl/rc4_xor_stage.sv
// RC4 keystream consumer: buffers the free-running PRGA bytes, optionally drops the first
// DROP_N of them, then XORs one keystream byte into each plaintext byte (valid/ready in and out).
module rc4_xor_stage #(
  parameter int FIFO_DEPTH = 16,
  parameter int DROP_N     = 0
) (
  input logic            clk,
  input logic            rst,
  rc4_xor_stage_if.slave bus
);
  localparam int          AW         = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(FIFO_DEPTH);
  localparam logic [15:0] DROP_LAST  = 16'(DROP_N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DROP = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t        state_reg;
  logic [15:0]   drop_cnt_reg;
  logic          running_reg;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   level_reg;
  logic          overflow_reg;

  logic          ct_valid_reg;
  logic [7:0]    ct_data_reg;
  logic [15:0]   byte_count_reg;

  logic          fifo_full;
  logic          fifo_empty;
  logic          pt_ready;
  logic          push_req;
  logic          push;
  logic          pop;
  logic [7:0]    head;

  assign fifo_full  = (level_reg == FULL_LEVEL);
  assign fifo_empty = (level_reg == '0);
  assign head       = mem[rd_ptr_reg];

  // Ready depends only on registered state and the sink's ready, never on pt_valid.
  assign pt_ready = running_reg & ~fifo_empty & (~ct_valid_reg | bus.ct_ready);
  assign pop      = bus.pt_valid & pt_ready;

  // With no drop phase the byte seen on the IDLE->RUN edge is already keystream.
  always_comb begin
    push_req = 1'b0;
    case (state_reg)
      IDLE:    push_req = bus.ks_valid && (DROP_N == 0);
      RUN:     push_req = bus.ks_valid;
      default: push_req = 1'b0;
    endcase
  end

  // A full FIFO still accepts a byte when its head leaves in the same cycle.
  assign push = push_req & (~fifo_full | pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      drop_cnt_reg <= '0;
      running_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.ks_valid) begin
            if (DROP_N > 0) begin
              drop_cnt_reg <= 16'd1;
            end
            if (DROP_N <= 1) begin
              state_reg   <= RUN;
              running_reg <= 1'b1;
            end else begin
              state_reg <= DROP;
            end
          end
        end
        DROP: begin
          if (bus.ks_valid) begin
            drop_cnt_reg <= drop_cnt_reg + 16'd1;
            if (drop_cnt_reg + 16'd1 == DROP_LAST) begin
              state_reg   <= RUN;
              running_reg <= 1'b1;
            end
          end
        end
        RUN: begin
          state_reg <= RUN;
        end
        default: begin
          state_reg   <= IDLE;
          running_reg <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= bus.ks_byte;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
      if (push_req && !push) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  // Output register: a new transfer may replace a byte that is handshaking this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ct_valid_reg   <= 1'b0;
      ct_data_reg    <= '0;
      byte_count_reg <= '0;
    end else begin
      if (pop) begin
        ct_valid_reg <= 1'b1;
        ct_data_reg  <= bus.pt_data ^ head;
      end else if (bus.ct_ready) begin
        ct_valid_reg <= 1'b0;
      end
      if (ct_valid_reg && bus.ct_ready) begin
        byte_count_reg <= byte_count_reg + 16'd1;
      end
    end
  end

  assign bus.pt_ready   = pt_ready;
  assign bus.ct_valid   = ct_valid_reg;
  assign bus.ct_data    = ct_data_reg;
  assign bus.running    = running_reg;
  assign bus.overflow   = overflow_reg;
  assign bus.byte_count = byte_count_reg;
endmodule
